// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: ALU, iterative shift-add multiply, flags, bypassed registered writeback
module exec_stage #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    op,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [DW-1:0] opnd_a,
    input  logic [DW-1:0] opnd_b,
    input  logic [DW-1:0] imm,
    input  logic          use_imm,
    output logic          wb_we,
    output logic [AW-1:0] wb_wa,
    output logic [DW-1:0] wb_wd,
    output logic [2:0]    flags,
    output logic          busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t state, state_nxt;

    logic          accept;
    logic          start_mul;
    logic          mul_done;

    logic          byp_a, byp_b;
    logic [DW-1:0] eff_a, eff_b;

    logic [DW:0]   sum, diff;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_fl_en;
    logic          alu_wr;

    logic [2*DW-1:0] mul_mcand;
    logic [DW-1:0]   mul_mplier;
    logic [2*DW-1:0] mul_acc;
    logic [2*DW-1:0] mul_step;
    logic [CW-1:0]   mul_cnt;
    logic [AW-1:0]   mul_dst;

    // The register file commits one edge after wb_*, so the pending writeback is forwarded.
    assign byp_a = wb_we && (wb_wa == src_a) && (src_a != '0);
    assign byp_b = wb_we && (wb_wa == src_b) && (src_b != '0);
    assign eff_a = byp_a ? wb_wd : opnd_a;
    assign eff_b = use_imm ? imm : (byp_b ? wb_wd : opnd_b);

    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (op == OP_MUL);
    assign mul_done  = (state == S_MUL) && (mul_cnt == LAST_ITER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (start_mul) begin
                    state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (mul_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sum  = {1'b0, eff_a} + {1'b0, eff_b};
    assign diff = {1'b0, eff_a} - {1'b0, eff_b};

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_fl_en = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];
            end
            OP_AND: alu_res = eff_a & eff_b;
            OP_OR:  alu_res = eff_a | eff_b;
            OP_XOR: alu_res = eff_a ^ eff_b;
            OP_SHL: begin
                alu_res = {eff_a[DW-2:0], 1'b0};
                alu_c   = eff_a[DW-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, eff_a[DW-1:1]};
                alu_c   = eff_a[0];
            end
            OP_MOV: alu_res = eff_b;
            default: alu_fl_en = 1'b0;
        endcase
    end

    assign alu_wr   = (op <= OP_MOV) && (dst != '0);
    assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we      <= 1'b0;
            wb_wa      <= '0;
            wb_wd      <= '0;
            flags      <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_acc    <= '0;
            mul_cnt    <= '0;
            mul_dst    <= '0;
        end else begin
            wb_we <= 1'b0;
            if (accept && (op != OP_MUL) && alu_fl_en) begin
                wb_we <= alu_wr;
                wb_wa <= dst;
                wb_wd <= alu_res;
                flags <= {alu_res[DW-1], alu_c, (alu_res == '0)};
            end
            if (start_mul) begin
                mul_mcand  <= {{DW{1'b0}}, eff_a};
                mul_mplier <= eff_b;
                mul_acc    <= '0;
                mul_cnt    <= '0;
                mul_dst    <= dst;
            end
            // One multiplier bit per cycle, LSB first.
            if (state == S_MUL) begin
                mul_acc    <= mul_step;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + 1'b1;
                if (mul_done) begin
                    wb_we <= (mul_dst != '0);
                    wb_wa <= mul_dst;
                    wb_wd <= mul_step[DW-1:0];
                    flags <= {mul_step[DW-1], (mul_step[2*DW-1:DW] != '0),
                              (mul_step[DW-1:0] == '0)};
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - scoreboard bench for exec_stage with architectural reference model
module tb_exec_stage;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    op = '0;
    logic [AW-1:0] dst = '0;
    logic [AW-1:0] src_a = '0;
    logic [AW-1:0] src_b = '0;
    logic [DW-1:0] opnd_a;
    logic [DW-1:0] opnd_b;
    logic [DW-1:0] imm = '0;
    logic          use_imm = 1'b0;
    logic          wb_we;
    logic [AW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;
    logic [2:0]    flags;
    logic          busy;

    always #5 clk = ~clk;

    exec_stage #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .dst      (dst),
        .src_a    (src_a),
        .src_b    (src_b),
        .opnd_a   (opnd_a),
        .opnd_b   (opnd_b),
        .imm      (imm),
        .use_imm  (use_imm),
        .wb_we    (wb_we),
        .wb_wa    (wb_wa),
        .wb_wd    (wb_wd),
        .flags    (flags),
        .busy     (busy)
    );

    // Register file stand-in: commits the writeback at the edge after it is presented.
    logic [DW-1:0] rf [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (wb_we && (wb_wa != 4'd0)) rf[wb_wa] <= wb_wd;
    end
    assign opnd_a = rf[src_a];
    assign opnd_b = rf[src_b];

    typedef struct {
        int         due;
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [2:0] fl;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       me;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_wait = 0;
    int         mreg [16];
    logic [2:0] last_fl = 3'b000;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every cycle either a scheduled result is due, or nothing may be written and flags hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_fl = 3'b000;
        end else if (mon_en) begin
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                me = exp_q.pop_front();
                chk("sb_wb_we", int'(wb_we), int'(me.we));
                if (me.we) begin
                    chk("sb_wb_wa", int'(wb_wa), int'(me.wa));
                    chk("sb_wb_wd", int'(wb_wd), int'(me.wd));
                end
                chk("sb_flags", int'(flags), int'(me.fl));
                last_fl = me.fl;
            end else begin
                chk("sb_idle_wb_we", int'(wb_we), 0);
                chk("sb_flags_hold", int'(flags), int'(last_fl));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; holds the op until accepted, then returns at the negedge after acceptance.
    task automatic issue(input logic [3:0] o, input logic [3:0] d, input logic [3:0] sa,
                         input logic [3:0] sb, input logic [7:0] im, input logic ui,
                         input bit model_on);
        int   w, a, b, r;
        logic c;
        exp_t e;
        op = o; dst = d; src_a = sa; src_b = sb; imm = im; use_imm = ui; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        chk("accept_ready", int'(in_ready), 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        if (model_on && o <= 4'd9) begin
            a = mreg[sa];
            b = ui ? int'(im) : mreg[sb];
            c = 1'b0;
            r = 0;
            case (o)
                4'd0: begin r = a + b; c = (r > 255); end
                4'd1, 4'd9: begin r = a - b; c = (a < b); end
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd5: begin r = a * 2; c = (a >= 128); end
                4'd6: begin r = a / 2; c = ((a % 2) == 1); end
                4'd7: r = b;
                default: begin r = a * b; c = (r > 255); end
            endcase
            r = r & 255;
            e.due = cyc + 1 + ((o == 4'd8) ? DW : 0);
            e.we  = (o <= 4'd8) && (d != 4'd0);
            e.wa  = d;
            e.wd  = r[7:0];
            e.fl  = {(r >= 128), c, (r == 0)};
            if (e.we) mreg[d] = r;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] ro, rd, rsa, rsb, prev_d;
        foreach (mreg[i]) mreg[i] = 0;
        idle(2);
        chk("rst_wb_we", int'(wb_we), 0);
        chk("rst_wb_wa", int'(wb_wa), 0);
        chk("rst_wb_wd", int'(wb_wd), 0);
        chk("rst_flags", int'(flags), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(1);

        issue(4'd7, 4'd5, 4'd0, 4'd0, 8'h7F, 1'b1, 1'b1);
        issue(4'd7, 4'd6, 4'd0, 4'd0, 8'hFF, 1'b1, 1'b1);
        issue(4'd7, 4'd2, 4'd0, 4'd0, 8'h55, 1'b1, 1'b1);
        idle(2);

        issue(4'd0, 4'd1, 4'd5, 4'd0, 8'h01, 1'b1, 1'b1);
        chk("add_we", int'(wb_we), 1);
        chk("add_wa", int'(wb_wa), 1);
        chk("add_wd", int'(wb_wd), 8'h80);
        chk("add_flags", int'(flags), 3'b100);
        idle(1);
        chk("add_pulse_end", int'(wb_we), 0);

        issue(4'd0, 4'd2, 4'd6, 4'd0, 8'h01, 1'b1, 1'b1);
        chk("add_wrap_wd", int'(wb_wd), 8'h00);
        chk("add_wrap_flags", int'(flags), 3'b011);
        issue(4'd1, 4'd3, 4'd2, 4'd0, 8'h01, 1'b1, 1'b1);
        chk("sub_bypass_wd", int'(wb_wd), 8'hFF);
        chk("sub_bypass_flags", int'(flags), 3'b110);
        idle(1);

        issue(4'd7, 4'd7, 4'd0, 4'd0, 8'h0D, 1'b1, 1'b1);
        issue(4'd7, 4'd8, 4'd0, 4'd0, 8'h0B, 1'b1, 1'b1);
        idle(1);
        issue(4'd8, 4'd4, 4'd7, 4'd8, 8'h00, 1'b0, 1'b1);
        chk("mul_busy", int'(busy), 1);
        issue(4'd0, 4'd9, 4'd4, 4'd0, 8'h00, 1'b1, 1'b1);
        chk("mul_stall_cycles", last_wait, DW);
        chk("mul_product_bypass", int'(wb_wd), 8'h8F);

        issue(4'd7, 4'd10, 4'd0, 4'd0, 8'h10, 1'b1, 1'b1);
        issue(4'd7, 4'd11, 4'd0, 4'd0, 8'h20, 1'b1, 1'b1);
        issue(4'd8, 4'd12, 4'd10, 4'd11, 8'h00, 1'b0, 1'b1);
        idle(DW);
        chk("mul2_we", int'(wb_we), 1);
        chk("mul2_wd", int'(wb_wd), 8'h00);
        chk("mul2_flags", int'(flags), 3'b011);
        chk("mul2_ready", int'(in_ready), 1);

        issue(4'd7, 4'd13, 4'd0, 4'd0, 8'h05, 1'b1, 1'b1);
        issue(4'd9, 4'd14, 4'd13, 4'd0, 8'h09, 1'b1, 1'b1);
        chk("cmp_we", int'(wb_we), 0);
        chk("cmp_flags", int'(flags), 3'b110);
        issue(4'd0, 4'd0, 4'd13, 4'd0, 8'hFB, 1'b1, 1'b1);
        chk("add_r0_we", int'(wb_we), 0);
        chk("add_r0_flags", int'(flags), 3'b011);

        issue(4'd7, 4'd1, 4'd0, 4'd0, 8'h81, 1'b1, 1'b1);
        issue(4'd5, 4'd2, 4'd1, 4'd0, 8'h00, 1'b1, 1'b1);
        chk("shl_wd", int'(wb_wd), 8'h02);
        chk("shl_flags", int'(flags), 3'b010);
        issue(4'd7, 4'd3, 4'd0, 4'd0, 8'h01, 1'b1, 1'b1);
        issue(4'd6, 4'd4, 4'd3, 4'd0, 8'h00, 1'b1, 1'b1);
        chk("shr_wd", int'(wb_wd), 8'h00);
        chk("shr_flags", int'(flags), 3'b011);
        issue(4'd12, 4'd5, 4'd1, 4'd2, 8'h00, 1'b0, 1'b1);
        chk("nop_we", int'(wb_we), 0);
        chk("nop_flags", int'(flags), 3'b011);

        prev_d = 4'd1;
        for (int i = 0; i < 200; i++) begin
            ro  = 4'($urandom_range(15));
            rd  = 4'($urandom_range(15));
            rsa = ($urandom_range(1) == 1) ? prev_d : 4'($urandom_range(15));
            rsb = ($urandom_range(1) == 1) ? prev_d : 4'($urandom_range(15));
            issue(ro, rd, rsa, rsb, 8'($urandom), 1'($urandom_range(1)), 1'b1);
            prev_d = rd;
            if ($urandom_range(3) == 0) idle($urandom_range(2));
        end
        idle(DW + 2);

        issue(4'd8, 4'd5, 4'd7, 4'd8, 8'h00, 1'b0, 1'b0);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("abort_wb_we", int'(wb_we), 0);
        chk("abort_wb_wa", int'(wb_wa), 0);
        chk("abort_wb_wd", int'(wb_wd), 0);
        chk("abort_flags", int'(flags), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(DW + 4);
        chk("abort_ready", int'(in_ready), 1);
        chk("abort_rf_r5", int'(rf[5]), mreg[5]);

        for (int i = 0; i < 30; i++) begin
            issue(4'($urandom_range(9)), 4'($urandom_range(15)), 4'($urandom_range(15)),
                  4'($urandom_range(15)), 8'($urandom), 1'($urandom_range(1)), 1'b1);
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        idle(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
